algo_6r1rw1w_a200_err_log: RTL
==============================

# algo_6r1rw1w_a200_err_log

Downstream error-event collector for the 6R+1RW+1W memory top. It watches the seven read-return channels (six read ports plus the RW port) for single- and double-bit ECC/parity error flags. Each flagged return is captured with its physical address and funnelled through a round-robin arbiter into a small FIFO, which a software-visible error log drains over a valid/ready handshake. It also keeps saturating error counters and a sticky overflow flag.

## Interface
- NUMRDPT, 7: read-return channels observed; 0..5 = rd ports, 6 = rw port
- BITRDPT, 3: width of port index
- BITPADR, 15: physical address width per channel
- FIFODEPTH, 8: error FIFO entries
- BITFIFO, 3: log2(FIFODEPTH)
- CNTWDTH, 16: counter width

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-low
- rd_vld  in  NUMRDPT  read data valid per channel
- rd_serr  in  NUMRDPT  single-bit (correctable) error, qualified by rd_vld
- rd_derr  in  NUMRDPT  double-bit (uncorrectable) error, qualified by rd_vld
- rd_padr  in  NUMRDPT*BITPADR  physical address per channel; channel i at [i*BITPADR +: BITPADR]
- clr  in  1  synchronous clear of counters, drop count and ovf
- err_vld  out  1  FIFO head valid
- err_rdy  in  1  consumer accepts head
- err_port  out  BITRDPT  channel index of head entry
- err_dbl  out  1  head entry is double-bit
- err_padr  out  BITPADR  address of head entry
- cnt_serr  out  CNTWDTH  saturating single-bit event count
- cnt_derr  out  CNTWDTH  saturating double-bit event count
- cnt_drop  out  CNTWDTH  saturating count of events lost to full slots
- ovf  out  1  sticky: at least one event dropped since reset/clr

## Operation
- Event on channel i: rd_vld[i] & (rd_serr[i] | rd_derr[i]). If both flags are set, the event is double-bit.
- Capture slots: one per channel, holding {full, dbl, padr}.
  - An event loads the slot if the slot is empty, or if it is being granted into the FIFO in the same cycle.
  - Otherwise the event is dropped: cnt_drop += 1 per dropped channel and ovf is set.
- Arbiter: each cycle, grant at most one full slot.
  - Search order starts at rr_ptr and increments modulo NUMRDPT.
  - A grant occurs only if the FIFO can accept: count < FIFODEPTH, or a pop happens this cycle.
  - After a grant, rr_ptr = (grant+1) mod NUMRDPT. With no grant, rr_ptr holds.
- FIFO: first-word-fall-through. err_vld = (count != 0), and the head fields are driven directly from storage.
  - Pop when err_vld & err_rdy.
  - Push and pop may occur in the same cycle, including when full; count is unchanged in that case.
  - Read/write pointers wrap modulo FIFODEPTH.
- Counters:
  - cnt_serr += number of single-only events this cycle (0..7).
  - cnt_derr += number of double-bit events this cycle.
  - Counting happens at detection, whether or not the event is dropped.
  - All counters saturate at 2^CNTWDTH-1 and never wrap.
- clr: takes priority over increments in its cycle. cnt_serr, cnt_derr and cnt_drop go to 0 and ovf goes to 0. Slots, FIFO and rr_ptr are unaffected. Events in the clr cycle are still captured but not counted.
- Asynchronous reset: all slots empty, FIFO empty (pointers 0), rr_ptr=0, all counters 0, ovf=0.
  - Reset values of all outputs are 0: err_vld, err_port, err_dbl, err_padr, cnt_*, ovf.
  - Reset mid-operation discards all pending entries with no partial outputs.

## Timing
- Event in cycle N: the slot is registered at the end of N.
- Earliest grant/push is cycle N+1. The entry is visible as err_vld=1 in cycle N+2, so detection-to-err_vld latency is 2 cycles.
- Counters and ovf update at the end of cycle N and are visible in N+1.
- A pop in cycle M shows the next head in cycle M+1.
- Sustained throughput: one error per cycle into the FIFO. A channel erroring every cycle while others are also flagged will drop events.
- err_rdy may be held high at all times. err_vld does not depend combinationally on err_rdy.

## Test plan
- Reset then single event: rst low→high; cycle 5 rd_vld=7'b0000100, rd_serr=7'b0000100, padr[2]=15'h1A5 → err_vld=1 in cycle 7 with err_port=2, err_dbl=0, err_padr=15'h1A5; cnt_serr=1 from cycle 6.
- Seven simultaneous errors: all channels serr=1, derr=1 on channel 6 only, err_rdy=1 → seven entries out in port order 0..6 on consecutive cycles; cnt_serr=6, cnt_derr=1, ovf=0.
- Backpressure/full: err_rdy=0, nine events on channel 0, spaced 2 cycles apart → FIFO holds 8 and slot 0 holds the 9th. A 10th event gives cnt_drop=1 and ovf=1. Raising err_rdy drains 9 entries in order.
- Same-slot reload: channel 3 erroring every cycle with the FIFO empty and err_rdy=1 → no drops. The slot is granted and reloaded each cycle, and cnt_drop stays 0.
- Saturation and clr: force 65540 derr events → cnt_derr holds 16'hFFFF. Assert clr alongside a new event → cnt_derr=0 next cycle, and the event still appears on err_vld.
- Round-robin fairness: channels 1 and 5 erroring continuously with err_rdy=1 → grants alternate 1,5,1,5. rr_ptr wraps 6→0 correctly when channel 6 is included.

Source files
------------

// File: rtl/algo_6r1rw1w_a200_err_log_if.sv
// Bus bundle for the error-log block: read-return error inputs, clear,
// the error-log valid/ready head and the counter/overflow status.
interface algo_6r1rw1w_a200_err_log_if;
   localparam int unsigned NUMRDPT = 7;
   localparam int unsigned BITRDPT = 3;
   localparam int unsigned BITPADR = 15;
   localparam int unsigned CNTWDTH = 16;

   logic [NUMRDPT-1:0]         rd_vld;
   logic [NUMRDPT-1:0]         rd_serr;
   logic [NUMRDPT-1:0]         rd_derr;
   logic [NUMRDPT*BITPADR-1:0] rd_padr;
   logic                       clr;
   logic                       err_vld;
   logic                       err_rdy;
   logic [BITRDPT-1:0]         err_port;
   logic                       err_dbl;
   logic [BITPADR-1:0]         err_padr;
   logic [CNTWDTH-1:0]         cnt_serr;
   logic [CNTWDTH-1:0]         cnt_derr;
   logic [CNTWDTH-1:0]         cnt_drop;
   logic                       ovf;

   modport master (
      output rd_vld, rd_serr, rd_derr, rd_padr, clr, err_rdy,
      input  err_vld, err_port, err_dbl, err_padr, cnt_serr, cnt_derr, cnt_drop, ovf
   );

   modport slave (
      input  rd_vld, rd_serr, rd_derr, rd_padr, clr, err_rdy,
      output err_vld, err_port, err_dbl, err_padr, cnt_serr, cnt_derr, cnt_drop, ovf
   );
endinterface

// File: rtl/algo_6r1rw1w_a200_err_log.sv
// Error-event collector for the 6R+1RW+1W memory: per-channel capture slots, a
// round-robin arbiter into a first-word-fall-through FIFO, and saturating counters.
module algo_6r1rw1w_a200_err_log (
   input logic                        clk,
   input logic                        rst,
   algo_6r1rw1w_a200_err_log_if.slave bus
);
   localparam int unsigned NUMRDPT   = 7;
   localparam int unsigned BITRDPT   = 3;
   localparam int unsigned BITPADR   = 15;
   localparam int unsigned FIFODEPTH = 8;
   localparam int unsigned BITFIFO   = 3;
   localparam int unsigned CNTWDTH   = 16;
   localparam int unsigned BITCNTF   = BITFIFO + 1;
   localparam int unsigned BITSUM    = BITRDPT + 1;

   typedef struct packed {
      logic [BITRDPT-1:0] port;
      logic               dbl;
      logic [BITPADR-1:0] padr;
   } ent_t;

   logic [NUMRDPT-1:0] evt;
   logic [NUMRDPT-1:0] evt_dbl;
   logic [NUMRDPT-1:0] evt_sgl;
   logic [NUMRDPT-1:0] load;
   logic [NUMRDPT-1:0] drop;
   logic [NUMRDPT-1:0] slot_full;
   logic [NUMRDPT-1:0] slot_full_nxt;
   logic [NUMRDPT-1:0] slot_dbl;
   logic [NUMRDPT-1:0] slot_dbl_nxt;
   logic [BITPADR-1:0] slot_padr     [NUMRDPT];
   logic [BITPADR-1:0] slot_padr_nxt [NUMRDPT];

   logic [BITRDPT-1:0] rr_ptr;
   logic [BITRDPT-1:0] rr_ptr_nxt;
   logic [BITRDPT-1:0] gnt_idx;
   logic               gnt_vld;
   logic [BITSUM-1:0]  arb_sum;

   ent_t               fifo_mem [FIFODEPTH];
   ent_t               push_ent;
   ent_t               head_ent;
   logic [BITFIFO-1:0] wr_ptr;
   logic [BITFIFO-1:0] wr_ptr_nxt;
   logic [BITFIFO-1:0] rd_ptr;
   logic [BITFIFO-1:0] rd_ptr_nxt;
   logic [BITCNTF-1:0] fifo_cnt;
   logic [BITCNTF-1:0] fifo_cnt_nxt;
   logic               err_vld_q;
   logic               push;
   logic               pop;
   logic               can_push;

   logic [CNTWDTH-1:0] cnt_serr_q;
   logic [CNTWDTH-1:0] cnt_serr_nxt;
   logic [CNTWDTH-1:0] cnt_derr_q;
   logic [CNTWDTH-1:0] cnt_derr_nxt;
   logic [CNTWDTH-1:0] cnt_drop_q;
   logic [CNTWDTH-1:0] cnt_drop_nxt;
   logic               ovf_q;
   logic               ovf_nxt;

   function automatic logic [BITRDPT-1:0] popcnt(input logic [NUMRDPT-1:0] v);
      logic [BITRDPT-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < NUMRDPT; i++) n = n + BITRDPT'(v[i]);
      return n;
   endfunction

   function automatic logic [CNTWDTH-1:0] sat_add(input logic [CNTWDTH-1:0] a,
                                                  input logic [BITRDPT-1:0] b);
      logic [CNTWDTH:0] s;
      s = {1'b0, a} + (CNTWDTH+1)'(b);
      return s[CNTWDTH] ? '1 : s[CNTWDTH-1:0];
   endfunction

   // Event decode; a return with both flags set counts as double-bit only.
   always_comb begin
      evt     = bus.rd_vld & (bus.rd_serr | bus.rd_derr);
      evt_dbl = bus.rd_vld & bus.rd_derr;
      evt_sgl = evt & ~evt_dbl;
   end

   assign pop      = err_vld_q & bus.err_rdy;
   assign can_push = (fifo_cnt < BITCNTF'(FIFODEPTH)) | pop;

   // Round-robin search from rr_ptr; only grants when the FIFO can take the entry.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      arb_sum = '0;
      for (int unsigned k = 0; k < NUMRDPT; k++) begin
         arb_sum = {1'b0, rr_ptr} + BITSUM'(k);
         if (arb_sum >= BITSUM'(NUMRDPT)) arb_sum = arb_sum - BITSUM'(NUMRDPT);
         if (!gnt_vld && can_push && slot_full[arb_sum[BITRDPT-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = arb_sum[BITRDPT-1:0];
         end
      end
      rr_ptr_nxt = rr_ptr;
      if (gnt_vld) rr_ptr_nxt = (gnt_idx == BITRDPT'(NUMRDPT-1)) ? '0 : gnt_idx + BITRDPT'(1);
   end

   assign push = gnt_vld;

   // Selected slot contents become the FIFO write data.
   always_comb begin
      push_ent = '0;
      for (int unsigned i = 0; i < NUMRDPT; i++) begin
         if (gnt_idx == BITRDPT'(i)) begin
            push_ent.port = BITRDPT'(i);
            push_ent.dbl  = slot_dbl[i];
            push_ent.padr = slot_padr[i];
         end
      end
   end

   // A slot being granted this cycle is free to reload; otherwise a busy slot drops.
   always_comb begin
      slot_full_nxt = slot_full;
      slot_dbl_nxt  = slot_dbl;
      slot_padr_nxt = slot_padr;
      load          = '0;
      drop          = '0;
      for (int unsigned i = 0; i < NUMRDPT; i++) begin
         load[i] = evt[i] & (~slot_full[i] | (gnt_vld & (gnt_idx == BITRDPT'(i))));
         drop[i] = evt[i] & ~load[i];
         if (load[i]) begin
            slot_full_nxt[i] = 1'b1;
            slot_dbl_nxt[i]  = evt_dbl[i];
            slot_padr_nxt[i] = bus.rd_padr[i*BITPADR +: BITPADR];
         end else if (gnt_vld && (gnt_idx == BITRDPT'(i))) begin
            slot_full_nxt[i] = 1'b0;
         end
      end
   end

   always_comb begin
      wr_ptr_nxt   = push ? wr_ptr + BITFIFO'(1) : wr_ptr;
      rd_ptr_nxt   = pop  ? rd_ptr + BITFIFO'(1) : rd_ptr;
      fifo_cnt_nxt = fifo_cnt;
      if (push && !pop)      fifo_cnt_nxt = fifo_cnt + BITCNTF'(1);
      else if (!push && pop) fifo_cnt_nxt = fifo_cnt - BITCNTF'(1);
   end

   // Clear wins over any increment in the same cycle.
   always_comb begin
      cnt_serr_nxt = sat_add(cnt_serr_q, popcnt(evt_sgl));
      cnt_derr_nxt = sat_add(cnt_derr_q, popcnt(evt_dbl));
      cnt_drop_nxt = sat_add(cnt_drop_q, popcnt(drop));
      ovf_nxt      = ovf_q | (|drop);
      if (bus.clr) begin
         cnt_serr_nxt = '0;
         cnt_derr_nxt = '0;
         cnt_drop_nxt = '0;
         ovf_nxt      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_full  <= '0;
         slot_dbl   <= '0;
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         err_vld_q  <= 1'b0;
         cnt_serr_q <= '0;
         cnt_derr_q <= '0;
         cnt_drop_q <= '0;
         ovf_q      <= 1'b0;
         for (int unsigned i = 0; i < NUMRDPT; i++)   slot_padr[i] <= '0;
         for (int unsigned j = 0; j < FIFODEPTH; j++) fifo_mem[j]  <= '0;
      end else begin
         slot_full  <= slot_full_nxt;
         slot_dbl   <= slot_dbl_nxt;
         slot_padr  <= slot_padr_nxt;
         rr_ptr     <= rr_ptr_nxt;
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         fifo_cnt   <= fifo_cnt_nxt;
         err_vld_q  <= (fifo_cnt_nxt != '0);
         cnt_serr_q <= cnt_serr_nxt;
         cnt_derr_q <= cnt_derr_nxt;
         cnt_drop_q <= cnt_drop_nxt;
         ovf_q      <= ovf_nxt;
         if (push) fifo_mem[wr_ptr] <= push_ent;
      end
   end

   // Head fields fall straight through from FIFO storage.
   assign head_ent     = fifo_mem[rd_ptr];
   assign bus.err_vld  = err_vld_q;
   assign bus.err_port = head_ent.port;
   assign bus.err_dbl  = head_ent.dbl;
   assign bus.err_padr = head_ent.padr;
   assign bus.cnt_serr = cnt_serr_q;
   assign bus.cnt_derr = cnt_derr_q;
   assign bus.cnt_drop = cnt_drop_q;
   assign bus.ovf      = ovf_q;
endmodule
